// File: rtl/pic_8259_pkg.sv
// Shared 8259 PIC definitions: level constants, rotation helpers and the
// fixed-priority one-hot scan used by the in-service block and the resolver.
package pic_8259_pkg;

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_LOWEST = 3'd7;

  typedef enum logic {
    ISR_IDLE = 1'b0,
    ISR_ACK  = 1'b1
  } isr_state_t;

  function automatic logic [7:0] rotate_right8(input logic [7:0] value,
                                               input logic [2:0] amount);
    logic [15:0] both;
    both = {value, value} >> amount;
    return both[7:0];
  endfunction

  function automatic logic [7:0] rotate_left8(input logic [7:0] value,
                                              input logic [2:0] amount);
    logic [15:0] both;
    both = {value, value} << amount;
    return both[15:8];
  endfunction

  // All-zero input maps to the lowest-priority code, which is the spurious vector.
  function automatic logic [2:0] onehot_to_bin3(input logic [7:0] value);
    logic [2:0] level;
    level = LEVEL_LOWEST;
    for (int i = 0; i < int'(NUM_LEVELS); i++) begin
      if (value[i]) level = 3'(i);
    end
    return level;
  endfunction

  function automatic logic [7:0] bin3_to_onehot(input logic [2:0] level);
    return 8'b0000_0001 << level;
  endfunction

  // Isolates the least-significant set bit; bit 0 is the highest priority.
  function automatic logic [7:0] fixed_priority_scan8(input logic [7:0] value);
    return value & 8'(~value + 8'd1);
  endfunction

endpackage

// File: rtl/isr_8259_scan.sv
// Combinational scan of the ISR for the highest-priority in-service bit
// under the current rotation.
module isr_8259_scan
  import pic_8259_pkg::*;
(
  input  logic [7:0] in_service_register,
  input  logic [2:0] priority_rotate,
  output logic [7:0] highest_level_in_service
);

  logic [2:0] shift_amount;
  logic [7:0] normalized;

  // Move the highest-priority level (rotate+1) down to bit 0, scan, move back.
  assign shift_amount = 3'(priority_rotate + 3'd1);
  assign normalized = rotate_right8(in_service_register, shift_amount);
  assign highest_level_in_service =
    rotate_left8(fixed_priority_scan8(normalized), shift_amount);

endmodule

// File: rtl/isr_8259.sv
// 8259 in-service control: ISR, rotation pointer, acknowledge sequencing
// and end-of-interrupt handling.
module isr_8259
  import pic_8259_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       latch_in_service,
  input  logic       end_of_acknowledge,
  input  logic       auto_eoi_config,
  input  logic       auto_rotate_mode,
  input  logic       eoi_command,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       set_priority_command,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] acknowledged_level,
  output logic       ack_busy
);

  isr_state_t state, state_next;
  logic [7:0] isr_next;
  logic [2:0] rotate_next;
  logic [7:0] eoi_next;
  logic [2:0] ack_level_next;
  logic [7:0] clear_mask;
  logic [7:0] set_mask;

  isr_8259_scan u_scan (
    .in_service_register      (in_service_register),
    .priority_rotate          (priority_rotate),
    .highest_level_in_service (highest_level_in_service)
  );

  assign ack_busy = (state == ISR_ACK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= ISR_IDLE;
      in_service_register <= 8'h00;
      priority_rotate     <= LEVEL_LOWEST;
      end_of_interrupt    <= 8'h00;
      acknowledged_level  <= LEVEL_LOWEST;
    end else begin
      state               <= state_next;
      in_service_register <= isr_next;
      priority_rotate     <= rotate_next;
      end_of_interrupt    <= eoi_next;
      acknowledged_level  <= ack_level_next;
    end
  end

  // Clears from AEOI and OCW2 are merged, then the INTA latch is applied on top.
  always_comb begin
    state_next     = state;
    rotate_next    = priority_rotate;
    ack_level_next = acknowledged_level;
    clear_mask     = 8'h00;
    set_mask       = 8'h00;

    case (state)
      ISR_IDLE: begin
        if (latch_in_service) begin
          set_mask       = interrupt;
          ack_level_next = onehot_to_bin3(interrupt);
          state_next     = ISR_ACK;
        end
      end
      ISR_ACK: begin
        if (end_of_acknowledge) begin
          if (auto_eoi_config) begin
            clear_mask = bin3_to_onehot(acknowledged_level);
            if (auto_rotate_mode) rotate_next = acknowledged_level;
          end
          state_next = ISR_IDLE;
        end
      end
      default: state_next = ISR_IDLE;
    endcase

    if (eoi_command) begin
      if (eoi_specific) begin
        clear_mask = clear_mask | bin3_to_onehot(eoi_level);
        if (rotate_on_eoi) rotate_next = eoi_level;
      end else if (highest_level_in_service != 8'h00) begin
        clear_mask = clear_mask | highest_level_in_service;
        if (rotate_on_eoi) rotate_next = onehot_to_bin3(highest_level_in_service);
      end
    end

    if (set_priority_command) rotate_next = eoi_level;

    eoi_next = in_service_register & clear_mask;
    isr_next = (in_service_register & ~clear_mask) | set_mask;
  end

endmodule

// File: tb/tb_isr_8259.sv
// Self-checking bench for isr_8259: directed scenarios followed by random
// stimulus against a level-by-level behavioural model.
module tb_isr_8259;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       latch_in_service, end_of_acknowledge;
  logic       auto_eoi_config, auto_rotate_mode;
  logic       eoi_command, eoi_specific, rotate_on_eoi, set_priority_command;
  logic [2:0] eoi_level;
  logic [7:0] in_service_register, highest_level_in_service, end_of_interrupt;
  logic [2:0] priority_rotate, acknowledged_level;
  logic       ack_busy;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit m_isr[8];
  int m_rot;
  int m_ack;
  bit m_busy;
  int m_pulse;

  isr_8259 dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .end_of_acknowledge       (end_of_acknowledge),
    .auto_eoi_config          (auto_eoi_config),
    .auto_rotate_mode         (auto_rotate_mode),
    .eoi_command              (eoi_command),
    .eoi_specific             (eoi_specific),
    .eoi_level                (eoi_level),
    .rotate_on_eoi            (rotate_on_eoi),
    .set_priority_command     (set_priority_command),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .end_of_interrupt         (end_of_interrupt),
    .acknowledged_level       (acknowledged_level),
    .ack_busy                 (ack_busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_isr_byte();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_isr[i]) v += (1 << i);
    return v;
  endfunction

  // Walk levels from the highest priority (rot+1) to the lowest (rot).
  function automatic int model_highest();
    for (int k = 1; k <= 8; k++) begin
      int lvl = (m_rot + k) % 8;
      if (m_isr[lvl]) return lvl;
    end
    return -1;
  endfunction

  function automatic int model_hlis_byte();
    int h = model_highest();
    return (h < 0) ? 0 : (1 << h);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
    m_rot = 7; m_ack = 7; m_busy = 1'b0; m_pulse = 0;
  endtask

  task automatic model_step();
    bit clr[8];
    int new_rot = m_rot;
    int h = model_highest();
    bit busy_next = m_busy;
    for (int i = 0; i < 8; i++) clr[i] = 1'b0;
    if (m_busy && end_of_acknowledge) begin
      if (auto_eoi_config) begin
        clr[m_ack] = 1'b1;
        if (auto_rotate_mode) new_rot = m_ack;
      end
      busy_next = 1'b0;
    end
    if (eoi_command) begin
      if (eoi_specific) begin
        clr[int'(eoi_level)] = 1'b1;
        if (rotate_on_eoi) new_rot = int'(eoi_level);
      end else if (h >= 0) begin
        clr[h] = 1'b1;
        if (rotate_on_eoi) new_rot = h;
      end
    end
    if (set_priority_command) new_rot = int'(eoi_level);
    m_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      if (clr[i] && m_isr[i]) m_pulse += (1 << i);
      if (clr[i]) m_isr[i] = 1'b0;
    end
    if (!m_busy && latch_in_service) begin
      int g = 7;
      for (int i = 0; i < 8; i++) if (interrupt[i]) g = i;
      if (interrupt != 8'h00) m_isr[g] = 1'b1;
      m_ack = g;
      busy_next = 1'b1;
    end
    m_rot = new_rot;
    m_busy = busy_next;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".isr"},   32'(in_service_register),      32'(model_isr_byte()));
    check_eq({tag, ".hlis"},  32'(highest_level_in_service), 32'(model_hlis_byte()));
    check_eq({tag, ".rot"},   32'(priority_rotate),          32'(m_rot));
    check_eq({tag, ".eoi"},   32'(end_of_interrupt),         32'(m_pulse));
    check_eq({tag, ".ack"},   32'(acknowledged_level),       32'(m_ack));
    check_eq({tag, ".busy"},  32'(ack_busy),                 32'(m_busy));
  endtask

  task automatic idle_inputs();
    interrupt = 8'h00; latch_in_service = 1'b0; end_of_acknowledge = 1'b0;
    eoi_command = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    rotate_on_eoi = 1'b0; set_priority_command = 1'b0;
  endtask

  // One clock: model advances with the same inputs, outputs checked 1 after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clock);
    #1;
    compare_all(tag);
    idle_inputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic latch(input logic [7:0] grant);
    interrupt = grant; latch_in_service = 1'b1; tick("latch");
    end_of_acknowledge = 1'b1; tick("eoa");
  endtask

  initial begin
    reset = 1'b1;
    auto_eoi_config = 1'b0; auto_rotate_mode = 1'b0;
    idle_inputs();
    @(posedge clock); #1;
    apply_reset();
    compare_all("reset");
    check_eq("reset.rot_const", 32'(priority_rotate), 32'd7);

    // Grant IR2
    interrupt = 8'b0000_0100; latch_in_service = 1'b1; tick("ir2");
    check_eq("ir2.isr_const",  32'(in_service_register), 32'h04);
    check_eq("ir2.ack_const",  32'(acknowledged_level), 32'd2);
    check_eq("ir2.hlis_const", 32'(highest_level_in_service), 32'h04);
    check_eq("ir2.busy_const", 32'(ack_busy), 32'd1);

    // AEOI at end of acknowledge
    auto_eoi_config = 1'b1;
    end_of_acknowledge = 1'b1; tick("aeoi");
    check_eq("aeoi.isr_const", 32'(in_service_register), 32'h00);
    check_eq("aeoi.eoi_const", 32'(end_of_interrupt), 32'h04);
    check_eq("aeoi.busy_const", 32'(ack_busy), 32'd0);
    tick("aeoi_after");
    check_eq("aeoi.eoi_drop", 32'(end_of_interrupt), 32'h00);
    auto_eoi_config = 1'b0;

    // Rotating non-specific EOI
    latch(8'h01); latch(8'h10);
    check_eq("ns.isr_pre", 32'(in_service_register), 32'h11);
    eoi_command = 1'b1; rotate_on_eoi = 1'b1; tick("ns_eoi");
    check_eq("ns.isr_const",  32'(in_service_register), 32'h10);
    check_eq("ns.rot_const",  32'(priority_rotate), 32'd0);
    check_eq("ns.hlis_const", 32'(highest_level_in_service), 32'h10);

    // Specific EOI under rotation 3
    apply_reset();
    eoi_level = 3'd3; set_priority_command = 1'b1; tick("setp");
    latch(8'h01); latch(8'h80);
    check_eq("sp.hlis_const", 32'(highest_level_in_service), 32'h80);
    eoi_command = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0; tick("sp_eoi");
    check_eq("sp.isr_const", 32'(in_service_register), 32'h80);
    check_eq("sp.eoi_const", 32'(end_of_interrupt), 32'h01);

    // Spurious latch, then non-specific EOI on an empty ISR
    apply_reset();
    latch(8'h00);
    check_eq("spur.isr_const", 32'(in_service_register), 32'h00);
    check_eq("spur.ack_const", 32'(acknowledged_level), 32'd7);
    eoi_command = 1'b1; rotate_on_eoi = 1'b1; tick("empty_eoi");
    check_eq("empty.eoi_const", 32'(end_of_interrupt), 32'h00);
    check_eq("empty.rot_const", 32'(priority_rotate), 32'd7);

    // Asynchronous reset while in ACK
    interrupt = 8'h20; latch_in_service = 1'b1; tick("ir5");
    check_eq("ir5.busy_const", 32'(ack_busy), 32'd1);
    reset = 1'b1; #2;
    model_reset();
    compare_all("async_rst");
    check_eq("async_rst.isr_const", 32'(in_service_register), 32'h00);
    reset = 1'b0; #1;

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) begin
        auto_eoi_config = 1'($urandom_range(0, 1));
        auto_rotate_mode = 1'($urandom_range(0, 1));
      end
      if (n % 150 == 149) apply_reset();
      interrupt = ($urandom_range(0, 8) == 8) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
      latch_in_service     = ($urandom_range(0, 2) == 0);
      end_of_acknowledge   = ($urandom_range(0, 2) == 0);
      eoi_command          = ($urandom_range(0, 4) == 0);
      eoi_specific         = 1'($urandom_range(0, 1));
      eoi_level            = 3'($urandom_range(0, 7));
      rotate_on_eoi        = 1'($urandom_range(0, 1));
      set_priority_command = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isr_8259.md
# isr_8259

In-service control for the 8259 PIC, the consumer of the priority resolver's one-hot `interrupt` grant. It owns the in-service register (ISR), the rotation pointer and the end-of-interrupt (EOI) logic. Its `in_service_register`, `highest_level_in_service` and `priority_rotate` outputs feed straight back into the resolver. It is sequenced by the INTA-derived strobes from the control logic and by OCW2 decoded commands.

## Interface
- No parameters; fixed 8 levels, 3-bit level codes.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `interrupt`  in  8  one-hot grant from the priority resolver; all-zero means no request.
- `latch_in_service`  in  1  one-cycle strobe at the first INTA; captures the grant.
- `end_of_acknowledge`  in  1  one-cycle strobe at the end of the INTA sequence.
- `auto_eoi_config`  in  1  ICW4 AEOI.
- `auto_rotate_mode`  in  1  rotate-in-AEOI mode.
- `eoi_command`  in  1  one-cycle OCW2 EOI strobe.
- `eoi_specific`  in  1  with `eoi_command`: 1 = specific, 0 = non-specific.
- `eoi_level`  in  3  level for a specific EOI or set-priority command.
- `rotate_on_eoi`  in  1  with `eoi_command`: rotate after clearing.
- `set_priority_command`  in  1  one-cycle strobe; loads `priority_rotate` from `eoi_level`.
- `in_service_register`  out  8  ISR.
- `highest_level_in_service`  out  8  one-hot highest-priority ISR bit under the current rotation; 0 when the ISR is empty.
- `priority_rotate`  out  3  lowest-priority level; the highest-priority level is `priority_rotate`+1 mod 8.
- `end_of_interrupt`  out  8  one-cycle pulse of the bits cleared this cycle; used by the IRR to re-arm.
- `acknowledged_level`  out  3  binary level captured at `latch_in_service`; used for the vector.
- `ack_busy`  out  1  high while in ACK.

## Operation
- Reset values:
  - `in_service_register` 0.
  - `highest_level_in_service` 0.
  - `priority_rotate` 3'b111, so IR0 is highest priority.
  - `end_of_interrupt` 0.
  - `acknowledged_level` 3'b111.
  - `ack_busy` 0.
  - FSM in IDLE.
- FSM has two states, IDLE and ACK.
- IDLE + `latch_in_service`:
  - ISR |= `interrupt`.
  - `acknowledged_level` <= binary of `interrupt`; all-zero grant (spurious) gives 7 and leaves the ISR unchanged.
  - Go to ACK.
- ACK + `end_of_acknowledge`:
  - If `auto_eoi_config`, clear the ISR bit at `acknowledged_level` and pulse it on `end_of_interrupt`.
  - If `auto_rotate_mode` is also set, `priority_rotate` <= `acknowledged_level`.
  - Go to IDLE.
- `latch_in_service` in ACK is ignored. `end_of_acknowledge` in IDLE is ignored.
- Non-specific EOI: clear the `highest_level_in_service` bit. If `rotate_on_eoi`, `priority_rotate` <= that level. With an empty ISR: no clear, no rotate, no pulse.
- Specific EOI: clear bit `eoi_level`, pulsing it only if it was set. If `rotate_on_eoi`, `priority_rotate` <= `eoi_level` unconditionally.
- `set_priority_command`: `priority_rotate` <= `eoi_level`. When it coincides with a rotating EOI, the set-priority value wins.
- Same-cycle latch and clear: clear is applied first, then set. The set wins for the same bit.
- `highest_level_in_service` is scanned from ISR bit `priority_rotate`+1 upward, mod 8.

## Timing
- All register updates occur on the rising edge following the strobe. One-cycle latency to `in_service_register`, `priority_rotate` and `acknowledged_level`.
- `highest_level_in_service` is combinational from the registered ISR and `priority_rotate`. It is valid in the same cycle the ISR updates; no extra latency.
- `end_of_interrupt` is high for exactly the one cycle after the clearing edge.
- An asynchronous reset mid-ACK returns to IDLE immediately and drops `ack_busy`. No EOI pulse is generated.
- Strobes are assumed to be single-cycle. A strobe held high repeats its action each cycle, except `latch_in_service`, which is ignored in ACK.

## Structure
- Shared package `pic_8259_pkg` holds:
  - level constants;
  - functions `rotate_right8`/`rotate_left8`, `onehot_to_bin3` and `bin3_to_onehot`;
  - the fixed-priority one-hot scan.
- These functions are shared with the priority resolver.
- One sub-module, `isr_8259_scan`, is combinational: ISR + rotate -> `highest_level_in_service`.
- FSM and registers live in `isr_8259`.

## Test plan
- Reset, then `interrupt`=8'b00000100 and `latch_in_service` -> ISR=8'h04, `acknowledged_level`=2, `highest_level_in_service`=8'h04, `ack_busy`=1.
- AEOI=1 with ISR=8'h04, then `end_of_acknowledge` -> ISR=0, `end_of_interrupt`=8'h04 for 1 cycle, IDLE.
- ISR=8'h11 with rotate=7, non-specific EOI with `rotate_on_eoi` -> ISR=8'h10, `priority_rotate`=0, then `highest_level_in_service`=8'h10.
- ISR=8'h81 with `priority_rotate`=3 -> `highest_level_in_service`=8'h80. A specific EOI at level 0 leaves ISR=8'h80 and pulses 8'h01.
- Spurious latch with `interrupt`=0 -> ISR unchanged, `acknowledged_level`=7. Non-specific EOI with empty ISR -> no pulse, rotate unchanged.
- Reset asserted in ACK with ISR=8'h20 -> all outputs at reset values before the next clock.
